// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit: byte lanes, load extension, split misaligned beats
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              bus_reqValid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wmask,
  output logic [1:0]        bus_size,
  input  logic              bus_respValid,
  input  logic [XLEN-1:0]   bus_rdata
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3} state_e;

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
    logic [XLEN-1:0] m;
    case (size)
      2'd0:    m = XLEN'(8'hFF);
      2'd1:    m = XLEN'(16'hFFFF);
      2'd2:    m = XLEN'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    return m;
  endfunction

  // The sign bit is the top set bit of the size mask, isolated by m ^ (m >> 1).
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo,
                                              input logic [OFFW-1:0] off, input logic [1:0] size,
                                              input logic sign);
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] m;
    logic            top;
    r   = XLEN'({hi, lo} >> {off, 3'b000});
    m   = size_mask(size);
    top = |(r & (m ^ (m >> 1)));
    return (r & m) | ({XLEN{top & sign}} & ~m);
  endfunction

  state_e            state_q, state_d;
  logic              reqv_q, reqv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, wdata_hi_q, wdata_hi_d;
  logic [BYTES-1:0]  mask_q, mask_d, mask_hi_q, mask_hi_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d, cross_q, cross_d, fault_q, fault_d;
  logic [XLEN-1:0]   lo_q, lo_d, rdata_q, rdata_d;

  logic [OFFW-1:0]    req_off;
  logic [3:0]         req_nb;
  logic [4:0]         req_span;
  logic               req_cross, req_misal, req_illegal;
  logic [2*BYTES-1:0] req_mask2;
  logic [2*XLEN-1:0]  req_wdata2;
  logic [ADDR_W-1:0]  req_base;

  // Request decode: a double-width mask/data image whose upper half is beat 1.
  always_comb begin
    req_off     = req_addr[OFFW-1:0];
    req_nb      = 4'd1 << req_size;
    req_span    = 5'(req_off) + 5'(req_nb);
    req_cross   = req_span > 5'(BYTES);
    req_misal   = (4'(req_off) & (req_nb - 4'd1)) != 4'd0;
    req_illegal = (req_size == 2'd3) && (XLEN < 64);
    req_mask2   = (((2*BYTES)'(1) << req_nb) - (2*BYTES)'(1)) << req_off;
    req_wdata2  = {{XLEN{1'b0}}, req_wdata & size_mask(req_size)} << {req_off, 3'b000};
    req_base    = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  end

  always_comb begin
    state_d    = state_q;
    reqv_d     = reqv_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wdata_hi_d = wdata_hi_q;
    mask_d     = mask_q;
    mask_hi_d  = mask_hi_q;
    off_d      = off_q;
    size_d     = size_q;
    sign_d     = sign_q;
    cross_d    = cross_q;
    fault_d    = fault_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_base;
          wen_d      = req_wen;
          wdata_d    = req_wdata2[XLEN-1:0];
          wdata_hi_d = req_wdata2[2*XLEN-1:XLEN];
          mask_d     = req_mask2[BYTES-1:0];
          mask_hi_d  = req_mask2[2*BYTES-1:BYTES];
          off_d      = req_off;
          size_d     = req_size;
          sign_d     = req_sign;
          cross_d    = req_cross;
          if (req_illegal || ((MISALIGN_EN == 0) && req_misal)) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            fault_d = 1'b0;
            reqv_d  = 1'b1;
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (reqv_q && bus_respValid) begin
          reqv_d = 1'b0;
          lo_d   = bus_rdata;
          if (cross_q) begin
            addr_d  = addr_q + ADDR_W'(BYTES);
            wdata_d = wdata_hi_q;
            mask_d  = mask_hi_q;
            state_d = BEAT1;
          end else begin
            rdata_d = wen_q ? '0 : extract('0, bus_rdata, off_q, size_q, sign_q);
            state_d = DONE;
          end
        end
      end
      BEAT1: begin
        // First BEAT1 cycle is the mandatory idle gap between beats.
        if (!reqv_q) begin
          reqv_d = 1'b1;
        end else if (bus_respValid) begin
          reqv_d  = 1'b0;
          rdata_d = wen_q ? '0 : extract(bus_rdata, lo_q, off_q, size_q, sign_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      reqv_q     <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wdata_hi_q <= '0;
      mask_q     <= '0;
      mask_hi_q  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      cross_q    <= 1'b0;
      fault_q    <= 1'b0;
      lo_q       <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      reqv_q     <= reqv_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wdata_hi_q <= wdata_hi_d;
      mask_q     <= mask_d;
      mask_hi_q  <= mask_hi_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      cross_q    <= cross_d;
      fault_q    <= fault_d;
      lo_q       <= lo_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign resp_fault   = (state_q == DONE) && fault_q;
  assign resp_rdata   = rdata_q;
  assign bus_reqValid = reqv_q;
  assign bus_addr     = addr_q;
  assign bus_wen      = wen_q;
  assign bus_wdata    = wdata_q;
  assign bus_wmask    = mask_q;
  assign bus_size     = 2'(OFFW);

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Self-checking bench for lsu_ctrl (32-bit split, 32-bit strict, 64-bit)
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u_a: XLEN=32, MISALIGN_EN=1
  logic a_req_valid, a_req_ready, a_req_wen, a_req_sign;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [1:0]  a_req_size, a_bus_size;
  logic a_resp_valid, a_resp_fault, a_bus_reqValid, a_bus_wen, a_bus_respValid;
  logic [3:0]  a_bus_wmask;
  // u_f: XLEN=32, MISALIGN_EN=0
  logic f_req_valid, f_req_ready, f_req_wen, f_req_sign;
  logic [31:0] f_req_addr, f_req_wdata, f_resp_rdata, f_bus_addr, f_bus_wdata, f_bus_rdata;
  logic [1:0]  f_req_size, f_bus_size;
  logic f_resp_valid, f_resp_fault, f_bus_reqValid, f_bus_wen, f_bus_respValid;
  logic [3:0]  f_bus_wmask;
  // u_d: XLEN=64, MISALIGN_EN=1
  logic d_req_valid, d_req_ready, d_req_wen, d_req_sign;
  logic [31:0] d_req_addr, d_bus_addr;
  logic [63:0] d_req_wdata, d_resp_rdata, d_bus_wdata, d_bus_rdata;
  logic [1:0]  d_req_size, d_bus_size;
  logic d_resp_valid, d_resp_fault, d_bus_reqValid, d_bus_wen, d_bus_respValid;
  logic [7:0]  d_bus_wmask;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u_a (
    .clock(clk), .reset(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_wen(a_req_wen), .req_addr(a_req_addr), .req_size(a_req_size), .req_sign(a_req_sign),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_fault(a_resp_fault), .bus_reqValid(a_bus_reqValid), .bus_addr(a_bus_addr),
    .bus_wen(a_bus_wen), .bus_wdata(a_bus_wdata), .bus_wmask(a_bus_wmask), .bus_size(a_bus_size),
    .bus_respValid(a_bus_respValid), .bus_rdata(a_bus_rdata));

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) u_f (
    .clock(clk), .reset(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_wen(f_req_wen), .req_addr(f_req_addr), .req_size(f_req_size), .req_sign(f_req_sign),
    .req_wdata(f_req_wdata), .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata),
    .resp_fault(f_resp_fault), .bus_reqValid(f_bus_reqValid), .bus_addr(f_bus_addr),
    .bus_wen(f_bus_wen), .bus_wdata(f_bus_wdata), .bus_wmask(f_bus_wmask), .bus_size(f_bus_size),
    .bus_respValid(f_bus_respValid), .bus_rdata(f_bus_rdata));

  lsu_ctrl #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1)) u_d (
    .clock(clk), .reset(rst_n), .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_wen(d_req_wen), .req_addr(d_req_addr), .req_size(d_req_size), .req_sign(d_req_sign),
    .req_wdata(d_req_wdata), .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata),
    .resp_fault(d_resp_fault), .bus_reqValid(d_bus_reqValid), .bus_addr(d_bus_addr),
    .bus_wen(d_bus_wen), .bus_wdata(d_bus_wdata), .bus_wmask(d_bus_wmask), .bus_size(d_bus_size),
    .bus_respValid(d_bus_respValid), .bus_rdata(d_bus_rdata));

  typedef struct {
    logic        wen;  logic [31:0] addr; logic [1:0] size; logic sign; logic [31:0] wdata;
    int          nbeats;
    logic [31:0] a0;   logic [3:0] m0;    logic [31:0] w0;  logic [31:0] r0; int l0;
    logic [31:0] a1;   logic [3:0] m1;    logic [31:0] w1;  logic [31:0] r1; int l1;
    logic [31:0] exp_rdata; logic exp_fault;
  } vec_t;
  typedef struct {
    logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; logic wen; logic [31:0] rdata; int lat;
  } beat_t;
  typedef struct { logic [31:0] rdata; logic fault; } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  vec_t  vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Drives one vector into u_a, acts as the bus, and checks against the scoreboard.
  task automatic run_a(input vec_t v, input string tag);
    beat_t cur;
    resp_t er;
    bit    done    = 1'b0;
    bit    in_beat = 1'b0;
    int    wcnt    = 0;
    cur = '{addr: 32'h0, mask: 4'h0, wdata: 32'h0, wen: 1'b0, rdata: 32'h0, lat: 0};
    if (v.nbeats >= 1) beat_q.push_back('{v.a0, v.m0, v.w0, v.wen, v.r0, v.l0});
    if (v.nbeats == 2) beat_q.push_back('{v.a1, v.m1, v.w1, v.wen, v.r1, v.l1});
    resp_q.push_back('{v.exp_rdata, v.exp_fault});
    @(negedge clk);
    a_req_valid = 1'b1; a_req_wen = v.wen; a_req_addr = v.addr;
    a_req_size  = v.size; a_req_sign = v.sign; a_req_wdata = v.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      a_bus_respValid = 1'b0;
      a_bus_rdata     = $urandom;
      // Garbage requests while busy must be ignored.
      a_req_valid = 1'b1; a_req_wen = 1'($urandom); a_req_addr = $urandom;
      a_req_size  = 2'($urandom); a_req_sign = 1'($urandom); a_req_wdata = $urandom;
      if (cyc == 0) check({tag, ".ready_busy"}, 64'(a_req_ready), 64'd0);
      if (a_resp_valid) begin
        a_req_valid = 1'b0;
        done        = 1'b1;
        er          = resp_q.pop_front();
        check({tag, ".rdata"}, 64'(a_resp_rdata), 64'(er.rdata));
        check({tag, ".fault"}, 64'(a_resp_fault), 64'(er.fault));
        check({tag, ".beats_left"}, 64'(beat_q.size()), 64'd0);
        if (v.exp_fault) check({tag, ".fault_latency"}, 64'(cyc), 64'd0);
      end else if (a_bus_reqValid) begin
        if (!in_beat) begin
          if (beat_q.size() == 0) begin
            fail_now({tag, ".unexpected_beat"});
          end else begin
            cur     = beat_q.pop_front();
            in_beat = 1'b1;
            wcnt    = 0;
            check({tag, ".addr"},  64'(a_bus_addr),  64'(cur.addr));
            check({tag, ".mask"},  64'(a_bus_wmask), 64'(cur.mask));
            check({tag, ".wdata"}, 64'(a_bus_wdata), 64'(cur.wdata));
            check({tag, ".wen"},   64'(a_bus_wen),   64'(cur.wen));
          end
        end else begin
          check({tag, ".addr_stable"}, 64'(a_bus_addr), 64'(cur.addr));
        end
        if (in_beat && wcnt == cur.lat) begin
          a_bus_respValid = 1'b1;
          a_bus_rdata     = cur.rdata;
          in_beat         = 1'b0;
        end
        wcnt++;
      end
    end
    a_req_valid = 1'b0;
    if (!done) fail_now({tag, ".resp_timeout"});
    @(negedge clk);
    a_bus_respValid = 1'b0;
    check({tag, ".resp_pulse"}, 64'(a_resp_valid), 64'd0);
    beat_q.delete();
    resp_q.delete();
  endtask

  task automatic f_fault(input logic [31:0] addr, input logic [1:0] size, input string tag);
    @(negedge clk);
    f_req_valid = 1'b1; f_req_wen = 1'b0; f_req_addr = addr; f_req_size = size;
    f_req_sign  = 1'b1; f_req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    f_req_valid = 1'b0;
    check({tag, ".resp_valid"}, 64'(f_resp_valid),   64'd1);
    check({tag, ".fault"},      64'(f_resp_fault),   64'd1);
    check({tag, ".rdata"},      64'(f_resp_rdata),   64'd0);
    check({tag, ".no_bus"},     64'(f_bus_reqValid), 64'd0);
    @(negedge clk);
    check({tag, ".pulse"},      64'(f_resp_valid),   64'd0);
    check({tag, ".no_bus2"},    64'(f_bus_reqValid), 64'd0);
  endtask

  task automatic d_issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [63:0] wdata);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_wen = wen; d_req_addr = addr; d_req_size = size;
    d_req_sign  = sign; d_req_wdata = wdata;
    @(negedge clk);
    d_req_valid = 1'b0;
  endtask

  task automatic d_beat(input logic [31:0] ea, input logic [7:0] em, input logic [63:0] rd,
                        input bit respond, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (d_bus_reqValid) begin
        seen = 1'b1;
        check({tag, ".addr"}, 64'(d_bus_addr),  64'(ea));
        check({tag, ".mask"}, 64'(d_bus_wmask), 64'(em));
        if (respond) begin
          d_bus_respValid = 1'b1;
          d_bus_rdata     = rd;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) fail_now({tag, ".beat_timeout"});
    if (respond) begin
      @(negedge clk);
      d_bus_respValid = 1'b0;
    end
  endtask

  task automatic d_wait_resp(input logic [63:0] exp, input logic fault, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (d_resp_valid) begin
        seen = 1'b1;
        check({tag, ".rdata"}, d_resp_rdata, exp);
        check({tag, ".fault"}, 64'(d_resp_fault), 64'(fault));
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) fail_now({tag, ".resp_timeout"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    a_req_valid = 0; a_req_wen = 0; a_req_addr = 0; a_req_size = 0; a_req_sign = 0; a_req_wdata = 0;
    a_bus_respValid = 0; a_bus_rdata = 0;
    f_req_valid = 0; f_req_wen = 0; f_req_addr = 0; f_req_size = 0; f_req_sign = 0; f_req_wdata = 0;
    f_bus_respValid = 0; f_bus_rdata = 0;
    d_req_valid = 0; d_req_wen = 0; d_req_addr = 0; d_req_size = 0; d_req_sign = 0; d_req_wdata = 0;
    d_bus_respValid = 0; d_bus_rdata = 0;

    //          wen  addr          sz    sg    wdata          nb  a0            m0    w0             r0             l0  a1            m1    w1             r1             l1  exp            flt
    vecs[0]  = '{1'b0, 32'h100,      2'd2, 1'b0, 32'h0,         1, 32'h100,      4'hF, 32'h0,         32'hDEADBEEF,  2, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'hDEADBEEF,  1'b0};
    vecs[1]  = '{1'b0, 32'h103,      2'd0, 1'b1, 32'h0,         1, 32'h100,      4'h8, 32'h0,         32'h80112233,  1, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'hFFFFFF80,  1'b0};
    vecs[2]  = '{1'b0, 32'h103,      2'd0, 1'b0, 32'h0,         1, 32'h100,      4'h8, 32'h0,         32'h80112233,  0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h00000080,  1'b0};
    vecs[3]  = '{1'b1, 32'h102,      2'd2, 1'b0, 32'hAABBCCDD,  2, 32'h100,      4'hC, 32'hCCDD0000,  32'h12345678,  1, 32'h104,      4'h3, 32'h0000AABB,  32'h9ABCDEF0,  2, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h107,      2'd1, 1'b1, 32'h0,         2, 32'h104,      4'h8, 32'h0,         32'h34000000,  0, 32'h108,      4'h1, 32'h0,         32'h000000F2,  1, 32'hFFFFF234,  1'b0};
    vecs[5]  = '{1'b1, 32'h101,      2'd0, 1'b0, 32'hFFFFFF5A,  1, 32'h100,      4'h2, 32'h00005A00,  32'hFFFFFFFF,  0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h102,      2'd1, 1'b0, 32'h0,         1, 32'h100,      4'hC, 32'h0,         32'h87654321,  0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h00008765,  1'b0};
    vecs[7]  = '{1'b1, 32'h003,      2'd1, 1'b0, 32'h00001234,  2, 32'h000,      4'h8, 32'h34000000,  32'h0,         1, 32'h004,      4'h1, 32'h00000012,  32'h0,         0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h0,         2, 32'hFFFFFFFC, 4'hC, 32'h0,         32'h55667788,  1, 32'h00000000, 4'h3, 32'h0,         32'h11223344,  3, 32'h33445566,  1'b0};
    vecs[9]  = '{1'b0, 32'h101,      2'd1, 1'b1, 32'h0,         1, 32'h100,      4'h6, 32'h0,         32'h00FF8000,  0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'hFFFFFF80,  1'b0};
    vecs[10] = '{1'b0, 32'h100,      2'd0, 1'b1, 32'h0,         1, 32'h100,      4'h1, 32'h0,         32'h0000007F,  2, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h0000007F,  1'b0};
    vecs[11] = '{1'b0, 32'h100,      2'd3, 1'b0, 32'h0,         0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h0,        4'h0, 32'h0,         32'h0,         0, 32'h0,         1'b1};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.a_ready",  64'(a_req_ready),    64'd1);
    check("rst.a_busreq", 64'(a_bus_reqValid), 64'd0);
    check("rst.a_resp",   64'(a_resp_valid),   64'd0);
    check("rst.a_fault",  64'(a_resp_fault),   64'd0);
    check("rst.a_rdata",  64'(a_resp_rdata),   64'd0);
    check("rst.a_addr",   64'(a_bus_addr),     64'd0);
    check("rst.a_wdata",  64'(a_bus_wdata),    64'd0);
    check("rst.a_wmask",  64'(a_bus_wmask),    64'd0);
    check("rst.a_size",   64'(a_bus_size),     64'd2);
    check("rst.d_size",   64'(d_bus_size),     64'd3);
    check("rst.d_busreq", 64'(d_bus_reqValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_a(vecs[i], $sformatf("v%0d", i));

    // Completed data holds, stray bus responses in IDLE are ignored.
    run_a(vecs[0], "hold");
    for (int i = 0; i < 3; i++) begin
      a_bus_respValid = 1'b1;
      a_bus_rdata     = $urandom;
      @(negedge clk);
      check("stray.resp_valid", 64'(a_resp_valid),   64'd0);
      check("stray.busreq",     64'(a_bus_reqValid), 64'd0);
      check("stray.rdata_hold", 64'(a_resp_rdata),   64'hDEADBEEF);
    end
    a_bus_respValid = 1'b0;

    // Strict alignment instance: aligned load works, misaligned/illegal sizes fault.
    @(negedge clk);
    f_req_valid = 1'b1; f_req_wen = 1'b0; f_req_addr = 32'h200; f_req_size = 2'd2;
    f_req_sign  = 1'b0; f_req_wdata = 32'h0;
    @(negedge clk);
    f_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (f_bus_reqValid) begin
        seen = 1'b1;
        check("f_ok.addr", 64'(f_bus_addr),  64'h200);
        check("f_ok.mask", 64'(f_bus_wmask), 64'hF);
        f_bus_respValid = 1'b1;
        f_bus_rdata     = 32'hCAFEF00D;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) fail_now("f_ok.beat_timeout");
    @(negedge clk);
    f_bus_respValid = 1'b0;
    check("f_ok.resp_valid", 64'(f_resp_valid), 64'd1);
    check("f_ok.rdata",      64'(f_resp_rdata), 64'hCAFEF00D);
    check("f_ok.fault",      64'(f_resp_fault), 64'd0);
    f_fault(32'h101, 2'd2, "f_misal");
    f_fault(32'h100, 2'd3, "f_size3");

    // 64-bit instance: reset while waiting on the second beat, then a clean LD.
    d_issue(1'b0, 32'h6, 2'd2, 1'b0, 64'h0);
    d_beat(32'h0, 8'hC0, 64'h1122334455667788, 1'b1, "d_b0");
    d_beat(32'h8, 8'h03, 64'h0, 1'b0, "d_b1");
    #2 rst_n = 1'b0;
    #1;
    check("d_rst.busreq", 64'(d_bus_reqValid), 64'd0);
    check("d_rst.resp",   64'(d_resp_valid),   64'd0);
    check("d_rst.ready",  64'(d_req_ready),    64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_bus_respValid = 1'b1;
    d_bus_rdata     = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    d_bus_respValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("d_late.resp",   64'(d_resp_valid),   64'd0);
      check("d_late.busreq", 64'(d_bus_reqValid), 64'd0);
      @(negedge clk);
    end
    d_issue(1'b0, 32'h8, 2'd3, 1'b0, 64'h0);
    d_beat(32'h8, 8'hFF, 64'h0123456789ABCDEF, 1'b1, "d_ld");
    d_wait_resp(64'h0123456789ABCDEF, 1'b0, "d_ld");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
